// File: rtl/wt_s_core.sv
// wt_s_core: registered 16x16 signed/unsigned Wallace-tree multiplier with a 32-bit product
module wt_s_csa #(
  parameter int N = 3,
  parameter int M = 2 * (N / 3) + N % 3
) (
  input  logic [31:0] x [N],
  output logic [31:0] y [M]
);
  for (genvar g = 0; g < N / 3; g++) begin : g_fa
    logic [31:0] a, b, c;
    assign a = x[3*g];
    assign b = x[3*g+1];
    assign c = x[3*g+2];
    assign y[2*g] = a ^ b ^ c;
    assign y[2*g+1] = {(a[30:0] & b[30:0]) | (a[30:0] & c[30:0]) | (b[30:0] & c[30:0]), 1'b0};
  end
  for (genvar g = 0; g < N % 3; g++) begin : g_pass
    assign y[2*(N/3)+g] = x[3*(N/3)+g];
  end
endmodule

module wt_s_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        alufn,
  output logic [31:0] C
);
  logic [16:0] a_ext, b_ext;
  logic [31:0] a32;
  logic [31:0] pp [18];
  logic [31:0] s1 [12];
  logic [31:0] s2 [8];
  logic [31:0] s3 [6];
  logic [31:0] s4 [4];
  logic [31:0] s5 [3];
  logic [31:0] s6 [2];
  assign a_ext = {~alufn & A[15], A};
  assign b_ext = {~alufn & B[15], B};
  assign a32 = {{15{a_ext[16]}}, a_ext};
  for (genvar i = 0; i < 16; i++) begin : g_pp
    assign pp[i] = (a32 & {32{b_ext[i]}}) << i;
  end
  // sign row is subtracted: -(A<<16) == {~A,16'h0} + 2^16, the +2^16 rides as its own row
  assign pp[16] = {~A & {16{b_ext[16]}}, 16'h0};
  assign pp[17] = {15'h0, b_ext[16], 16'h0};
  wt_s_csa #(.N(18)) u_s1 (.x(pp), .y(s1));
  wt_s_csa #(.N(12)) u_s2 (.x(s1), .y(s2));
  wt_s_csa #(.N(8))  u_s3 (.x(s2), .y(s3));
  wt_s_csa #(.N(6))  u_s4 (.x(s3), .y(s4));
  wt_s_csa #(.N(4))  u_s5 (.x(s4), .y(s5));
  wt_s_csa #(.N(3))  u_s6 (.x(s5), .y(s6));
  always_ff @(posedge clk) C <= rst ? 32'h0 : s6[0] + s6[1];
endmodule

// File: tb/tb_wt_s_core.sv
// tb_wt_s_core: directed and random scoreboard checks of the registered multiplier
module tb_wt_s_core;
  logic clk = 1'b0, rst = 1'b1, alufn = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [31:0] C;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [31:0] v; string tag;} exp_t;
  exp_t sb[$];

  wt_s_core dut (.clk(clk), .rst(rst), .A(A), .B(B), .alufn(alufn), .C(C));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic f);
    longint x, y, p;
    x = f ? {48'h0, a} : {{48{a[15]}}, a};
    y = f ? {48'h0, b} : {{48{b[15]}}, b};
    p = x * y;
    return p[31:0];
  endfunction

  task automatic step(input logic r, input logic f, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] e, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; alufn = f; A = a; B = b;
    x.v = e; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n_chk++;
    assert (C === x.v) n_pass++;
    else $error("FAIL %s: C=%h expected %h", x.tag, C, x.v);
  endtask

  initial begin
    step(1, 0, 16'h1234, 16'h5678, 32'h0000_0000, "rst_hold0");
    step(1, 0, 16'h1234, 16'h5678, 32'h0000_0000, "rst_hold1");
    step(0, 0, 16'h1234, 16'h5678, 32'h0626_0060, "rst_release");
    step(0, 0, 16'd36,   16'd36,   32'h0000_0510, "s_36x36");
    step(0, 0, 16'hFFDC, 16'd36,   32'hFFFF_FAF0, "s_m36x36");
    step(0, 0, 16'd0,    16'd36,   32'h0000_0000, "s_0x36");
    step(0, 0, 16'hFFDC, 16'hFFDC, 32'h0000_0510, "s_m36xm36");
    step(0, 1, 16'd36,   16'hFFDC, 32'h0023_FAF0, "u_36xFFDC");
    step(0, 1, 16'd0,    16'd0,    32'h0000_0000, "u_0x0");
    step(0, 1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "u_FFFFxFFFF");
    step(0, 0, 16'hFFFF, 16'hFFFF, 32'h0000_0001, "s_FFFFxFFFF");
    step(0, 0, 16'h8000, 16'h8000, 32'h4000_0000, "s_8000x8000");
    step(0, 0, 16'h8000, 16'h7FFF, 32'hC000_8000, "s_8000x7FFF");
    step(0, 0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "s_7FFFx7FFF");
    step(0, 1, 16'h8000, 16'h8000, 32'h4000_0000, "u_8000x8000");
    step(1, 1, 16'hFFFF, 16'hFFFF, 32'h0000_0000, "rst_mid");
    step(0, 1, 16'h7FFF, 16'hFFFF, 32'h7FFE_8001, "u_after_rst");
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      logic f, r;
      a = 16'($urandom);
      b = 16'($urandom);
      f = 1'($urandom);
      r = (i % 97) == 50;
      step(r, f, a, b, r ? 32'h0 : ref_mul(a, b, f), r ? "rand_rst" : "rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
